imem_loader: RTL and testbench

Write-side companion to the 64×32 instruction memory. It receives a program as a byte stream over a valid/ready handshake and packs the bytes into 32-bit little-endian words. It issues one write per word into the instruction RAM, then checks a trailing XOR checksum. While loading, it holds the single-cycle core in reset, and it releases the core only after a verified load.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader_word_packer.sv | 44 ++++
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The count byte is compared against the legal word-count range defined here.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_e;

   localparam int        IMEM_WORDS = 64;
   localparam logic [7:0] CNT_MIN   = 8'd1;
   localparam logic [7:0] CNT_MAX   = 8'd64;

   function automatic logic count_legal(input logic [7:0] b);
      return (b >= CNT_MIN) && (b <= CNT_MAX);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, RAM write-port and core-control signals of the loader.
// The loader is the slave; the host/bench side is the master.
interface imem_loader_if #(
   parameter int N  = 32,
   parameter int AW = 6
) ();
   logic          start;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [N-1:0]  wr_data;
   logic          hold_cpu;
   logic          done;
   logic          err;

   modport master (
      output start, byte_valid, byte_data,
      input  byte_ready, wr_en, wr_addr, wr_data, hold_cpu, done, err
   );

   modport slave (
      input  start, byte_valid, byte_data,
      output byte_ready, wr_en, wr_addr, wr_data, hold_cpu, done, err
   );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Four-lane byte shift register that assembles little-endian words.
// word_nxt is the word as it would look with byte_in shifted in this cycle.
module word_packer #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   input  logic [7:0]   byte_in,
   output logic [N-1:0] word_nxt,
   output logic         word_last
);

   logic [N-1:0] word_q, word_d;
   logic [1:0]   lane_q, lane_d;

   // Bytes enter at the top and move down, so the first byte ends in lane 0.
   assign word_nxt  = {byte_in, word_q[N-1:8]};
   assign word_last = (lane_q == 2'd3);

   always_comb begin
      word_d = word_q;
      lane_d = lane_q;
      if (clr) begin
         word_d = '0;
         lane_d = 2'd0;
      end else if (en) begin
         word_d = word_nxt;
         lane_d = lane_q + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q <= '0;
         lane_q <= 2'd0;
      end else begin
         word_q <= word_d;
         lane_q <= lane_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a checksummed byte-stream program into the instruction RAM and
// keeps the core in reset until a load has been verified.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int N  = 32,
   parameter int AW = 6
) (
   input  logic         clk,
   input  logic         reset,
   imem_loader_if.slave bus
);

   state_e        state_q, state_d;
   logic [AW:0]   w_q, w_d;
   logic [AW:0]   word_idx_q, word_idx_d, word_idx_inc;
   logic [7:0]    acc_q, acc_d;
   logic          byte_ready_q, byte_ready_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [N-1:0]  wr_data_q, wr_data_d;
   logic          hold_q, hold_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          accept;
   logic          pk_clr, pk_en, pk_last;
   logic [N-1:0]  pk_word;

   assign accept       = bus.byte_valid & byte_ready_q;
   assign word_idx_inc = word_idx_q + 1'b1;

   word_packer #(.N(N)) u_packer (
      .clk      (clk),
      .reset    (reset),
      .clr      (pk_clr),
      .en       (pk_en),
      .byte_in  (bus.byte_data),
      .word_nxt (pk_word),
      .word_last(pk_last)
   );

   always_comb begin
      state_d    = state_q;
      w_d        = w_q;
      word_idx_d = word_idx_q;
      acc_d      = acc_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      pk_clr     = 1'b0;
      pk_en      = 1'b0;

      case (state_q)
         S_IDLE: if (bus.start) state_d = S_COUNT;
         S_COUNT: begin
            if (accept) begin
               if (count_legal(bus.byte_data)) begin
                  w_d        = bus.byte_data[AW:0];
                  word_idx_d = '0;
                  acc_d      = 8'h00;
                  pk_clr     = 1'b1;
                  state_d    = S_DATA;
               end else begin
                  state_d = S_ERROR;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               pk_en = 1'b1;
               acc_d = acc_q ^ bus.byte_data;
               if (pk_last) begin
                  wr_en_d    = 1'b1;
                  wr_addr_d  = word_idx_q[AW-1:0];
                  wr_data_d  = pk_word;
                  word_idx_d = word_idx_inc;
                  if (word_idx_inc == w_q) state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (accept) state_d = (bus.byte_data == acc_q) ? S_DONE : S_ERROR;
         end
         S_DONE, S_ERROR: if (bus.start) state_d = S_COUNT;
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they align with it.
   always_comb begin
      byte_ready_d = (state_d == S_COUNT) || (state_d == S_DATA) || (state_d == S_CHECK);
      hold_d       = byte_ready_d || (state_d == S_ERROR);
      done_d       = (state_d == S_DONE);
      err_d        = (state_d == S_ERROR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         w_q          <= '0;
         word_idx_q   <= '0;
         acc_q        <= 8'h00;
         byte_ready_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         hold_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         w_q          <= w_d;
         word_idx_q   <= word_idx_d;
         acc_q        <= acc_d;
         byte_ready_q <= byte_ready_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         hold_q       <= hold_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign bus.byte_ready = byte_ready_q;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.hold_cpu   = hold_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad loads, illegal counts, stalls,
// full-depth load and reset during a load.
module tb_imem_loader;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   imem_loader_if #(.N(32), .AW(6)) bus ();

   imem_loader #(.N(32), .AW(6)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Write log, captured mid-cycle.
   logic [5:0]  log_addr [0:255];
   logic [31:0] log_data [0:255];
   int          wr_cnt = 0;

   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         if (wr_cnt < 256) begin
            log_addr[wr_cnt] = bus.wr_addr;
            log_data[wr_cnt] = bus.wr_data;
         end
         wr_cnt = wr_cnt + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      t = 0;
      while (bus.byte_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (bus.byte_ready !== 1'b1) begin
         check("byte_ready_timeout", {63'd0, bus.byte_ready}, 64'd1);
         bus.byte_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 bus.byte_valid = 1'b0;
      end
   endtask

   task automatic start_pulse();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Hand-built two-word stream; checksum F8^01^80^F8 = 81.
   task automatic good_stream(input logic [7:0] csum, input int maxgap, input bit mid_start);
      logic [7:0] s [0:8];
      s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hF8, 8'h01, 8'h80, 8'h00, 8'hF8};
      for (int i = 0; i < 9; i++) begin
         send_byte(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
         if (mid_start && i == 3) start_pulse();
      end
      send_byte(csum, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic check_two_writes(input string tag, input int base);
      check({tag, "_wrcnt"}, 64'(wr_cnt - base), 64'd2);
      check({tag, "_addr0"}, {58'd0, log_addr[base]}, 64'd0);
      check({tag, "_data0"}, {32'd0, log_data[base]}, 64'hF800_0000);
      check({tag, "_addr1"}, {58'd0, log_addr[base+1]}, 64'd1);
      check({tag, "_data1"}, {32'd0, log_data[base+1]}, 64'hF800_8001);
   endtask

   function automatic logic [7:0] fd_byte(input int k, input int j);
      return 8'((k * 16) + (j * 5) + 3);
   endfunction

   initial begin
      int base;
      logic [7:0] acc;
      bus.start      = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      reset          = 1'b1;

      // Reset state
      #2;
      check("rst_byte_ready", {63'd0, bus.byte_ready}, 64'd0);
      check("rst_wr_en",      {63'd0, bus.wr_en},      64'd0);
      check("rst_wr_addr",    {58'd0, bus.wr_addr},    64'd0);
      check("rst_wr_data",    {32'd0, bus.wr_data},    64'd0);
      check("rst_status",     {61'd0, bus.hold_cpu, bus.done, bus.err}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Good load
      base = wr_cnt;
      start_pulse();
      check("start_byte_ready", {63'd0, bus.byte_ready}, 64'd1);
      check("start_hold",       {63'd0, bus.hold_cpu},   64'd1);
      good_stream(8'h81, 0, 1'b0);
      check("good_status", {61'd0, bus.hold_cpu, bus.done, bus.err}, 64'b010);
      check_two_writes("good", base);

      // Bad checksum, then restart from ERROR
      base = wr_cnt;
      start_pulse();
      check("restart_done_clr", {63'd0, bus.done}, 64'd0);
      good_stream(8'h00, 0, 1'b0);
      check("bad_status", {61'd0, bus.hold_cpu, bus.done, bus.err}, 64'b101);
      check_two_writes("bad", base);
      start_pulse();
      check("err_restart_ready", {62'd0, bus.byte_ready, bus.err}, 64'b10);

      // Illegal count 00
      base = wr_cnt;
      send_byte(8'h00, 0);
      check("cnt00_status", {61'd0, bus.hold_cpu, bus.done, bus.err}, 64'b101);
      check("cnt00_ready",  {63'd0, bus.byte_ready}, 64'd0);
      repeat (3) @(negedge clk);
      check("cnt00_nowr", 64'(wr_cnt - base), 64'd0);

      // Illegal count 41
      base = wr_cnt;
      start_pulse();
      send_byte(8'h41, 0);
      check("cnt41_status", {61'd0, bus.hold_cpu, bus.done, bus.err}, 64'b101);
      repeat (3) @(negedge clk);
      check("cnt41_nowr", 64'(wr_cnt - base), 64'd0);

      // Stalls and a start pulse during DATA
      base = wr_cnt;
      start_pulse();
      good_stream(8'h81, 3, 1'b1);
      check("stall_status", {61'd0, bus.hold_cpu, bus.done, bus.err}, 64'b010);
      check_two_writes("stall", base);

      // Full depth, W = 64
      base = wr_cnt;
      acc  = 8'h00;
      start_pulse();
      send_byte(8'h40, 0);
      for (int k = 0; k < 64; k++)
         for (int j = 0; j < 4; j++) begin
            send_byte(fd_byte(k, j), 0);
            acc = acc ^ fd_byte(k, j);
         end
      send_byte(acc, 0);
      check("full_status", {61'd0, bus.hold_cpu, bus.done, bus.err}, 64'b010);
      check("full_wrcnt",  64'(wr_cnt - base), 64'd64);
      for (int k = 0; k < 64; k++) begin
         check("full_addr", {58'd0, log_addr[base+k]}, 64'(k));
         check("full_data", {32'd0, log_data[base+k]},
               {32'd0, fd_byte(k, 3), fd_byte(k, 2), fd_byte(k, 1), fd_byte(k, 0)});
      end

      // Reset after word 10 of a full-depth load
      base = wr_cnt;
      start_pulse();
      send_byte(8'h40, 0);
      for (int k = 0; k < 11; k++)
         for (int j = 0; j < 4; j++) send_byte(fd_byte(k, j), 0);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("midrst_outputs",
            {56'd0, bus.byte_ready, bus.wr_en, bus.hold_cpu, bus.done, bus.err, 3'b000}, 64'd0);
      check("midrst_wr_addr", {58'd0, bus.wr_addr}, 64'd0);
      check("midrst_wr_data", {32'd0, bus.wr_data}, 64'd0);
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'hAA;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst_idle_ready", {63'd0, bus.byte_ready}, 64'd0);
      bus.byte_valid = 1'b0;
      check("midrst_wrcnt", 64'(wr_cnt - base), 64'd11);
      check("midrst_last_addr", {58'd0, log_addr[base+10]}, 64'd10);

      // Fresh load after the abort
      base = wr_cnt;
      start_pulse();
      good_stream(8'h81, 0, 1'b0);
      check("fresh_status", {61'd0, bus.hold_cpu, bus.done, bus.err}, 64'b010);
      check_two_writes("fresh", base);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
